// File: rtl/port_rd_sched.sv
// port_rd_sched: egress-port read scheduler choosing which of NQ queues to drain.
// Strict priority (index 0 highest) or weighted round robin with per-queue credits.
// Optional build macro PORT_RD_ANTI_STARVE_EN adds per-queue wait counters that
// force a long-waiting queue through in strict mode.
// rd_prior is registered; the selection for the next cycle is built from the
// current registered credits/pointer, so an update shows up one edge later.
module port_rd_sched #(
    parameter int NQ       = 8,
    parameter int WEIGHT_W = 4,
    parameter int PW       = $clog2(NQ) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wrr_en,
    input  logic [NQ-1:0]          queue_empty,
    input  logic [NQ*WEIGHT_W-1:0] weights,
    input  logic                   update,
    output logic [PW-1:0]          rd_prior
);

    localparam logic [PW-1:0] NONE = PW'(NQ);
    localparam logic [PW-1:0] LAST = PW'(NQ - 1);

    logic [WEIGHT_W-1:0] credit_q [NQ];
    logic [WEIGHT_W-1:0] credit_d [NQ];
    logic [WEIGHT_W-1:0] cred_eff [NQ];
    logic [PW-1:0]       ptr_q, ptr_d, ptr_eff;
    logic                mode_q, mode_chg;
    logic [NQ-1:0]       eligible, wgt_nz, cand, wtd;
    logic                reload, dec_ok;
    logic [PW-1:0]       strict_sel, prior_d;

    // First set bit of vec searching cyclically from start; NONE if vec is empty.
    // The wrap is an explicit compare so NQ need not be a power of two.
    function automatic logic [PW-1:0] cyc_first(input logic [NQ-1:0] vec,
                                                input logic [PW-1:0] start);
        logic [PW-1:0] idx;
        logic [PW-1:0] res;
        logic          found;
        idx   = start;
        res   = NONE;
        found = 1'b0;
        for (int k = 0; k < NQ; k++) begin
            for (int j = 0; j < NQ; j++) begin
                if (!found && idx == PW'(j) && vec[j]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
        return res;
    endfunction

    // Per-queue qualification; a mode change behaves as if credits and pointer were already cleared.
    always_comb begin
        mode_chg = (wrr_en != mode_q);
        ptr_eff  = mode_chg ? '0 : ptr_q;
        eligible = ~queue_empty;
        for (int i = 0; i < NQ; i++) begin
            wgt_nz[i]   = |weights[i*WEIGHT_W +: WEIGHT_W];
            cred_eff[i] = mode_chg ? '0 : credit_q[i];
            cand[i]     = eligible[i] & wgt_nz[i] & (|cred_eff[i]);
        end
        wtd    = eligible & wgt_nz;
        reload = wrr_en && (cand == '0) && (wtd != '0);
    end

`ifdef PORT_RD_ANTI_STARVE_EN
    logic [7:0]    wait_q [NQ];
    logic [7:0]    wait_d [NQ];
    logic [PW-1:0] starve_sel;

    // Wait counters age eligible queues passed over by a strict-mode dequeue.
    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            wait_d[i] = wait_q[i];
            if (wrr_en || !eligible[i]) begin
                wait_d[i] = '0;
            end else if (update && rd_prior != NONE) begin
                if (rd_prior == PW'(i)) begin
                    wait_d[i] = '0;
                end else if (wait_q[i] != 8'hFF) begin
                    wait_d[i] = wait_q[i] + 8'd1;
                end
            end
        end
    end
`endif

    // Next selection: strict lowest index, or cyclic WRR search (reload falls back to weighted queues).
    always_comb begin
        strict_sel = NONE;
        for (int i = NQ - 1; i >= 0; i--) begin
            if (eligible[i]) strict_sel = PW'(i);
        end
`ifdef PORT_RD_ANTI_STARVE_EN
        starve_sel = NONE;
        for (int i = NQ - 1; i >= 0; i--) begin
            if (eligible[i] && wait_q[i] == 8'hFF) starve_sel = PW'(i);
        end
        if (starve_sel != NONE) strict_sel = starve_sel;
`endif
        if (!wrr_en)       prior_d = strict_sel;
        else if (|cand)    prior_d = cyc_first(cand, ptr_eff);
        else               prior_d = cyc_first(wtd, ptr_eff);
    end

    // Credit reload first, then the dequeue charge against the queue currently shown.
    always_comb begin
        ptr_d  = ptr_eff;
        dec_ok = wrr_en && update && !mode_chg && (rd_prior != NONE);
        for (int i = 0; i < NQ; i++) begin
            credit_d[i] = reload ? weights[i*WEIGHT_W +: WEIGHT_W] : cred_eff[i];
            if (dec_ok && rd_prior == PW'(i) && credit_d[i] != '0) begin
                credit_d[i] = credit_d[i] - 1'b1;
                if (credit_d[i] == '0) ptr_d = (rd_prior == LAST) ? '0 : rd_prior + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_prior <= NONE;
            ptr_q    <= '0;
            mode_q   <= 1'b0;
            for (int i = 0; i < NQ; i++) credit_q[i] <= '0;
`ifdef PORT_RD_ANTI_STARVE_EN
            for (int i = 0; i < NQ; i++) wait_q[i] <= '0;
`endif
        end else begin
            rd_prior <= prior_d;
            ptr_q    <= ptr_d;
            mode_q   <= wrr_en;
            for (int i = 0; i < NQ; i++) credit_q[i] <= credit_d[i];
`ifdef PORT_RD_ANTI_STARVE_EN
            for (int i = 0; i < NQ; i++) wait_q[i] <= wait_d[i];
`endif
        end
    end

endmodule

// File: doc/port_rd_sched.md
# port_rd_sched

Parametrised read-side queue scheduler for an egress port: selects which of `NQ` priority queues the port read path drains next. It supports strict-priority and weighted-round-robin (WRR) modes with per-queue programmable weights. It sits between the per-queue empty flags of the port's queue manager and the port read engine, which pulses `update` once per dequeued packet.

## Interface
Parameters:
- `NQ`, 8: number of queues; must be ≥2.
- `WEIGHT_W`, 4: bits per queue weight.
- `PW`, `$clog2(NQ)+1`: width of `rd_prior`, derived; do not override.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `wrr_en`  in  1  1 = WRR mode, 0 = strict priority (index 0 highest).
- `queue_empty`  in  `NQ`  per-queue empty flag; 1 = empty.
- `weights`  in  `NQ*WEIGHT_W`  packed weights; queue i is `weights[i*WEIGHT_W +: WEIGHT_W]`.
- `update`  in  1  one-cycle pulse: one packet dequeued from the queue currently shown on `rd_prior`.
- `rd_prior`  out  `PW`  selected queue index 0..NQ-1; the value `NQ` means no queue eligible.

## Operation
- State: `credit[i]` (`WEIGHT_W` bits each), round pointer `ptr` (0..NQ-1), last mode `mode_q`, registered `rd_prior`.
- Eligibility: queue i is eligible when `queue_empty[i]==0`.
- Strict mode (`wrr_en=0`): the next `rd_prior` is the lowest-index eligible queue, or `NQ` if there is none. Credits and `ptr` are frozen.
- WRR mode (`wrr_en=1`): queue i is a candidate when it is eligible, `weights[i]!=0` and `credit[i]!=0`.
  - The next `rd_prior` is the first candidate searching cyclically from `ptr` (ptr, ptr+1, …, wrapping at NQ-1→0).
  - If there is no candidate but some eligible queue has a nonzero weight, that is a round boundary:
    - load `credit[i] <= weights[i]` for all i;
    - in the same cycle, select the first eligible queue with nonzero weight cyclically from `ptr`.
  - An eligible queue with weight 0 is never served in WRR mode. This starvation is intentional and is how a queue is disabled.
  - If no queue qualifies, the next `rd_prior` is `NQ`.
- Update handling (both modes):
  - `update` while `rd_prior==NQ` is ignored.
  - In WRR mode, `update` decrements `credit[rd_prior]`, saturating at 0.
  - If the decrement reaches 0, `ptr <= (rd_prior+1) mod NQ`.
  - If the selected queue becomes ineligible while it still holds credit, it keeps that credit. `ptr` is unchanged, so the search naturally moves past it.
- Mode change: when `wrr_en != mode_q`, all credits clear to 0 and `ptr <= 0`. The first WRR selection then triggers a reload.
- Arithmetic: `ptr` wrap uses an explicit compare to `NQ-1`, not power-of-two truncation; `NQ` need not be a power of two.

## Timing
- Reset values: `rd_prior = NQ`, `ptr = 0`, all `credit = 0`, `mode_q = 0`.
- `rd_prior` is registered and recomputed every cycle.
  - A change on `queue_empty`, `wrr_en` or `weights` appears on `rd_prior` one cycle later.
  - The effect of `update` on credits and pointer is visible on `rd_prior` one cycle after the pulse.
- `update` and a credit reload in the same cycle: the reload wins for all queues, then the decrement is applied to `credit[rd_prior]`.
- Back-to-back `update` pulses are legal; each pulse consumes one credit.
- `weights` are sampled only at reload or when a weight is compared against 0. Changing weights mid-round takes effect at the next reload.
- `rst_n` low mid-round returns all state to its reset values on that edge. No partial round survives.

## Configuration
- `PORT_RD_ANTI_STARVE_EN` defined: strict mode gains a per-queue 8-bit wait counter.
  - The counter increments on each `update` not granted to that queue while the queue is eligible.
  - It clears when the queue is served or becomes empty.
  - A counter at 255 forces that queue as the next selection, lowest index first among saturated queues.
  - WRR mode is unaffected.
- Without the macro: pure strict priority, and none of this logic is present.

## Test plan
- Reset, all empty: `rd_prior==8` throughout; `update` pulses are ignored; credits stay 0.
- Strict, NQ=8, queues 2,5,7 nonempty: `rd_prior==2`. Empty queue 2 → `rd_prior==5` one cycle later.
- WRR, weights {1,2,3,0,0,0,0,0}, queues 0–2 always nonempty, 12 `update` pulses: grant sequence 0,1,1,2,2,2,0,1,1,2,2,2.
- WRR, weights all 2, queue 3 goes empty after 1 grant: queue 3 is skipped and its remaining credit is retained. When it refills before the round boundary it receives exactly 1 more grant, then a reload occurs.
- Toggle `wrr_en` 1→0→1 mid-round: credits clear and `ptr==0`; the first WRR grant goes to the lowest eligible weighted queue.
- With `PORT_RD_ANTI_STARVE_EN`, strict mode, queues 0 and 6 always nonempty: after 255 grants to queue 0, the next grant goes to queue 6, then service returns to queue 0.
